// File: rtl/mdu_divider.sv
`default_nettype none
// ============================================================================
// Module   : mdu_divider
// Purpose  : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//            One quotient bit per cycle, sign fix-up in a final cycle, and a
//            registered result qualified by a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] C_ALL_ONE = {XLEN{1'b1}};

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      op_q, op_d;
  logic            negq_q, negq_d;   // quotient must be negated
  logic            negr_q, negr_d;   // remainder must be negated
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;

  // Per-cycle scratch values derived from inputs / current state
  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;

  // Next-state and datapath logic for the divider FSM
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;

    w_signed  = ~op[0];
    w_a_neg   = w_signed & dividend[XLEN-1];
    w_b_neg   = w_signed & divisor[XLEN-1];

    // Trial subtraction is one bit wider than XLEN so the borrow is visible
    w_rem_sh  = {rem_q, quo_q[XLEN-1]};
    w_diff    = w_rem_sh - {1'b0, dvs_q};

    w_quo_fix = negq_q ? (~quo_q + 1'b1) : quo_q;
    w_rem_fix = negr_q ? (~rem_q + 1'b1) : rem_q;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d    = op;
          negq_d  = w_a_neg ^ w_b_neg;
          negr_d  = w_a_neg;
          quo_d   = w_a_neg ? (~dividend + 1'b1) : dividend;
          dvs_d   = w_b_neg ? (~divisor + 1'b1) : divisor;
          rem_d   = '0;
          count_d = CW'(XLEN);
          if (divisor == '0) begin
            // Division by zero: architectural results, no iteration
            result_d = op[1] ? dividend : C_ALL_ONE;
            state_d  = S_DONE;
          end else if (w_signed && dividend == C_MIN_NEG && divisor == C_ALL_ONE) begin
            // Signed overflow: quotient wraps to the most negative value
            result_d = op[1] ? '0 : C_MIN_NEG;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (!w_diff[XLEN]) begin
          rem_d = w_diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = w_rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = op_q[1] ? w_rem_fix : w_quo_fix;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything and leaves the visible result untouched
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      op_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_divider
// Purpose  : Directed self-checking bench for mdu_divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_divider;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  localparam int LAT_NORM = 34;  // samples after start edge until done (E33->E34)
  localparam int LAT_SPEC = 1;   // special-case done in the cycle after E0

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks;
  int n_errors;

  mdu_divider #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive a request in the current cycle; returns just after the start edge
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    op       = 2'($urandom);
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Wait (bounded) for done; check latency, busy coverage, result, one-cycle pulse
  task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res);
    int n        = 0;
    int busy_low = 0;
    bit seen     = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (!busy) busy_low++;
      if (done) begin
        seen = 1;
        break;
      end
    end
    check_eq({tag, ".seen"}, 32'(seen), 32'd1);
    check_eq({tag, ".lat"}, 32'(n), 32'(exp_lat));
    check_eq({tag, ".busy"}, 32'(busy_low), 32'd0);
    check_eq({tag, ".res"}, result, exp_res);
    @(negedge clk);
    check_eq({tag, ".pulse"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res, input int lat);
    start_op(o, a, b);
    wait_done(tag, lat, exp_res);
  endtask

  initial begin
    int dn;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    op       = 2'd0;
    dividend = 32'd0;
    divisor  = 32'd0;

    #2;
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    check_eq("rst.res", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic unsigned and signed arithmetic
    run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_NORM);
    run("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, LAT_NORM);
    run("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_NORM);
    run("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_NORM);
    run("div_7_m2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_NORM);
    run("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, LAT_NORM);

    // Divide by zero and signed overflow complete in one cycle
    run("divu_5_0",   OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPEC);
    run("rem_x_0",    OP_REM,  32'h8000_0001, 32'd0, 32'h8000_0001, LAT_SPEC);
    run("div_5_0",    OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPEC);
    run("remu_5_0",   OP_REMU, 32'd5, 32'd0, 32'd5, LAT_SPEC);
    run("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC);
    run("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_SPEC);

    // Second start during iteration 5 must be ignored
    start_op(OP_DIVU, 32'd1000, 32'd10);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    op       = OP_REMU;
    dividend = 32'd50;
    divisor  = 32'd3;
    @(posedge clk);
    #1;
    start    = 1'b0;
    wait_done("ign_start", LAT_NORM - 6, 32'd100);

    // Flush at iteration 10: back to idle, no done, result held
    start_op(OP_DIVU, 32'd77, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("flush.busy", 32'(busy), 32'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check_eq("flush.nodone", 32'(dn), 32'd0);
    check_eq("flush.res", result, 32'd100);

    // Flush wins over a simultaneous start in idle
    @(negedge clk);
    start    = 1'b1;
    flush    = 1'b1;
    op       = OP_DIVU;
    dividend = 32'd8;
    divisor  = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check_eq("flush_start.busy", 32'(busy), 32'd0);

    run("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_NORM);

    // Asynchronous reset mid-calculation
    start_op(OP_DIVU, 32'd1000, 32'd10);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst.busy", 32'(busy), 32'd0);
    check_eq("arst.done", 32'(done), 32'd0);
    check_eq("arst.res", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check_eq("arst.nodone", 32'(dn), 32'd0);

    run("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LAT_NORM);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
